aes_round_scheduler: RTL and testbench

AES_ROUND_SCHEDULER -- requirements
Module: aes_round_scheduler

---
 rtl/aes_round_scheduler_if.sv | 29 ++
 rtl/aes_round_scheduler.sv | 133 +++++++++++++
 tb/tb_aes_round_scheduler.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_scheduler_if.sv
`timescale 1ns/1ps
// Control bundle between the AES decryption round scheduler, the I/O block,
// the key-expansion unit and the datapath.
interface aes_round_scheduler_if;
  // Handshake: io_ready is a level held by the I/O block for the whole job;
  // dropping it aborts any busy state. aes_ready stays high in DONE until
  // io_ready is seen low. keyexp_start is a single-cycle pulse, and
  // keyexp_done is a level that is honoured from the cycle after that pulse.
  logic       io_ready;
  logic       keyexp_done;
  logic       keyexp_start;
  logic [2:0] op_sel;
  logic       op_en;
  logic [3:0] round_idx;
  logic [1:0] col_sel;
  logic       busy;
  logic       aes_ready;
  logic [2:0] fsm_state;

  modport master (
    input  io_ready, keyexp_done,
    output keyexp_start, op_sel, op_en, round_idx, col_sel, busy, aes_ready, fsm_state
  );

  modport slave (
    output io_ready, keyexp_done,
    input  keyexp_start, op_sel, op_en, round_idx, col_sel, busy, aes_ready, fsm_state
  );
endinterface

// File: rtl/aes_round_scheduler.sv
`timescale 1ns/1ps
// AES-128 decryption round scheduler: sequences LOAD, ADD_RK, INV_SHIFT,
// INV_SUB and column-serial INV_MIX over rounds 10..0 on a shared datapath.
module aes_round_scheduler (
  input  logic                  clk,
  input  logic                  reset_n,
  aes_round_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KEYEXP = 3'd1,
    S_LOAD   = 3'd2,
    S_ARK    = 3'd3,
    S_SHIFT  = 3'd4,
    S_SUB    = 3'd5,
    S_MIX    = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_ARK   = 3'd2;
  localparam logic [2:0] OP_SHIFT = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_MIX   = 3'd5;

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [1:0] col_q, col_d;
  logic       start_q, start_d;
  logic       in_busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      col_q   <= 2'd0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      col_q   <= col_d;
      start_q <= start_d;
    end
  end

  assign in_busy = (state_q != S_IDLE) && (state_q != S_DONE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    col_d   = col_q;
    start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        idx_d = 4'd0;
        col_d = 2'd0;
        if (bus.io_ready) begin
          state_d = S_KEYEXP;
          start_d = 1'b1;
        end
      end
      // keyexp_done may still be stale from a previous job while start is high
      S_KEYEXP: begin
        if (!start_q && bus.keyexp_done) begin
          state_d = S_LOAD;
          idx_d   = 4'd10;
          col_d   = 2'd0;
        end
      end
      S_LOAD:  state_d = S_ARK;
      S_ARK: begin
        col_d = 2'd0;
        if (idx_q >= 4'd10) begin
          state_d = S_SHIFT;
          idx_d   = 4'd9;
        end else if (idx_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_MIX;
        end
      end
      S_SHIFT: state_d = S_SUB;
      S_SUB:   state_d = S_ARK;
      S_MIX: begin
        if (col_q == 2'd3) begin
          col_d   = 2'd0;
          idx_d   = (idx_q != 4'd0) ? idx_q - 4'd1 : 4'd0;
          state_d = S_SHIFT;
        end else begin
          col_d = col_q + 2'd1;
        end
      end
      S_DONE: begin
        if (!bus.io_ready) begin
          state_d = S_IDLE;
          idx_d   = 4'd0;
          col_d   = 2'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort outranks every normal transition, including keyexp_done in KEYEXP
    if (in_busy && !bus.io_ready) begin
      state_d = S_IDLE;
      idx_d   = 4'd0;
      col_d   = 2'd0;
      start_d = 1'b0;
    end
  end

  always_comb begin
    bus.op_sel = OP_NOP;
    bus.op_en  = 1'b0;
    case (state_q)
      S_LOAD:  begin bus.op_sel = OP_LOAD;  bus.op_en = 1'b1; end
      S_ARK:   begin bus.op_sel = OP_ARK;   bus.op_en = 1'b1; end
      S_SHIFT: begin bus.op_sel = OP_SHIFT; bus.op_en = 1'b1; end
      S_SUB:   begin bus.op_sel = OP_SUB;   bus.op_en = 1'b1; end
      S_MIX:   begin bus.op_sel = OP_MIX;   bus.op_en = 1'b1; end
      default: begin bus.op_sel = OP_NOP;   bus.op_en = 1'b0; end
    endcase
    bus.busy         = in_busy;
    bus.aes_ready    = (state_q == S_DONE);
    bus.keyexp_start = start_q;
    bus.round_idx    = idx_q;
    bus.col_sel      = col_q;
    bus.fsm_state    = state_q;
  end

endmodule

// File: tb/tb_aes_round_scheduler.sv
`timescale 1ns/1ps
// Self-checking bench for aes_round_scheduler: scoreboarded op stream plus
// directed checks of handshake, abort and reset behaviour.
module tb_aes_round_scheduler;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  aes_round_scheduler_if bus ();

  aes_round_scheduler dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Entry layout: {op_sel, round_idx, col_sel}
  task automatic push_op(input int op, input int r, input int c);
    exp_q.push_back({3'(op), 4'(r), 2'(c)});
  endtask

  task automatic push_run();
    push_op(1, 10, 0);
    push_op(2, 10, 0);
    for (int r = 9; r >= 1; r--) begin
      push_op(3, r, 0);
      push_op(4, r, 0);
      push_op(2, r, 0);
      for (int c = 0; c < 4; c++) push_op(5, r, c);
    end
    push_op(3, 0, 0);
    push_op(4, 0, 0);
    push_op(2, 0, 0);
  endtask

  always @(negedge clk) begin
    if (bus.op_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("op_unexpected", 32'(bus.op_en), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("op_stream", {23'd0, bus.op_sel, bus.round_idx, bus.col_sel}, {23'd0, mon_e});
      end
    end
  end

  // Cycle c counts negedges after io_ready is raised; cycle 1 is the first KEYEXP cycle.
  task automatic drive_run(input int kd_delay, input bit tie_done,
                           output int first_op, output int last_op, output int n_ops,
                           output int ready_cyc, output int load_cyc, output int ke_width);
    first_op = -1; last_op = -1; n_ops = 0; ready_cyc = -1; load_cyc = -1; ke_width = 0;
    bus.io_ready    = 1'b1;
    bus.keyexp_done = tie_done;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (bus.keyexp_start) ke_width++;
      if (c == kd_delay + 1) bus.keyexp_done = 1'b1;
      if (bus.fsm_state == 3'd2 && load_cyc < 0) load_cyc = c;
      if (bus.op_en) begin
        n_ops++;
        if (first_op < 0) first_op = c;
        last_op = c;
      end
      if (bus.aes_ready) begin
        ready_cyc = c;
        break;
      end
    end
  endtask

  task automatic check_run(input string tag, input int exp_load, input int first_op, input int last_op,
                           input int n_ops, input int ready_cyc, input int load_cyc, input int ke_width);
    check({tag, "_ke_width"}, ke_width, 1);
    check({tag, "_load_cyc"}, load_cyc, exp_load);
    check({tag, "_first_op"}, first_op, exp_load);
    check({tag, "_n_ops"}, n_ops, 68);
    check({tag, "_last_op"}, last_op, exp_load + 67);
    check({tag, "_ready_cyc"}, ready_cyc, exp_load + 68);
    check({tag, "_q_empty"}, exp_q.size(), 0);
  endtask

  task automatic finish_run(input string tag);
    bus.io_ready    = 1'b0;
    bus.keyexp_done = 1'b0;
    @(negedge clk);
    check({tag, "_idle_state"}, bus.fsm_state, 0);
    check({tag, "_idle_ready"}, bus.aes_ready, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, bus.fsm_state, 0);
    check({tag, "_op_en"}, bus.op_en, 0);
    check({tag, "_op_sel"}, bus.op_sel, 0);
    check({tag, "_round_idx"}, bus.round_idx, 0);
    check({tag, "_col_sel"}, bus.col_sel, 0);
    check({tag, "_keyexp_start"}, bus.keyexp_start, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_aes_ready"}, bus.aes_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f, l, n, rdy, ld, kw, cnt;
    bit found, saw_ready;

    bus.io_ready    = 1'b0;
    bus.keyexp_done = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_wait_state", bus.fsm_state, 0);

    // Nominal run, keyexp_done five cycles after the start pulse
    push_run();
    drive_run(5, 1'b0, f, l, n, rdy, ld, kw);
    check_run("nominal", 7, f, l, n, rdy, ld, kw);

    // Held io_ready in DONE must not retrigger
    bus.keyexp_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_aes_ready", bus.aes_ready, 1);
      check("hold_no_start", {bus.keyexp_start, bus.busy}, 0);
    end
    finish_run("after_hold");

    // Second run with keyexp_done tied high including the start cycle
    push_run();
    drive_run(0, 1'b1, f, l, n, rdy, ld, kw);
    check_run("tied_done", 3, f, l, n, rdy, ld, kw);
    finish_run("after_tied");

    // Abort in MIX of round 5 at column 2
    push_run();
    bus.io_ready    = 1'b1;
    bus.keyexp_done = 1'b0;
    found = 1'b0;
    saw_ready = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (bus.aes_ready) saw_ready = 1'b1;
      if (c == 2) bus.keyexp_done = 1'b1;
      if (bus.fsm_state == 3'd6 && bus.round_idx == 4'd5 && bus.col_sel == 2'd2) begin
        bus.io_ready = 1'b0;
        found = 1'b1;
        break;
      end
    end
    check("abort_point_found", found, 1);
    @(negedge clk);
    check_all_zero("abort");
    check("abort_ops_left", exp_q.size(), 32);
    exp_q.delete();
    bus.keyexp_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.aes_ready) saw_ready = 1'b1;
    end
    check("abort_never_ready", saw_ready, 0);
    check("abort_stays_idle", bus.fsm_state, 0);

    // Asynchronous reset after the 30th op cycle
    push_run();
    bus.io_ready    = 1'b1;
    bus.keyexp_done = 1'b0;
    cnt = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (c == 2) bus.keyexp_done = 1'b1;
      if (bus.op_en) cnt++;
      if (cnt == 30) break;
    end
    check("reset_op_count", cnt, 30);
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    exp_q.delete();
    @(negedge clk);
    check_all_zero("reset_held");
    reset_n = 1'b1;
    #1 check("reset_release_no_edge", bus.fsm_state, 0);
    push_run();
    drive_run(2, 1'b0, f, l, n, rdy, ld, kw);
    check_run("post_reset", 4, f, l, n, rdy, ld, kw);
    finish_run("after_reset_run");

    // io_ready drop and keyexp_done in the same KEYEXP cycle
    bus.io_ready    = 1'b1;
    bus.keyexp_done = 1'b0;
    @(negedge clk);
    check("simul_start_pulse", bus.keyexp_start, 1);
    @(negedge clk);
    check("simul_in_keyexp", bus.fsm_state, 1);
    bus.io_ready    = 1'b0;
    bus.keyexp_done = 1'b1;
    @(negedge clk);
    check_all_zero("simul_abort");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("simul_no_load", bus.op_en, 0);
    end
    bus.keyexp_done = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
